// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the MIPS core: sequences MULT/MULTU/DIV/DIVU one bit per cycle
// and stalls any HI/LO access or new issue while an operation is in flight.
module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  input  logic            rd_req,
  input  logic            wr_req,
  input  logic            wr_sel,
  input  logic [XLEN-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t              state, state_nxt;
  logic [1:0]          op_q;
  logic [XLEN-1:0]     a_q, b_q, mc;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       cnt;
  logic                sign_q, sign_r, divz;

  logic                is_div, is_signed;
  logic [XLEN:0]       add_sum, shl_rem, sub_rem;
  logic [2*XLEN-1:0]   mul_nxt, div_nxt, prod;
  logic [XLEN-1:0]     res_hi, res_lo;

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] x, input logic en);
    return (en && x < 0) ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic signed [XLEN-1:0] x, input logic en);
    return en ? $unsigned(-x) : $unsigned(x);
  endfunction

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !cancel) state_nxt = PREP;
      PREP:    state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && cancel) state_nxt = IDLE;
  end

  always_comb begin
    busy  = (state != IDLE);
    stall = busy & (rd_req | wr_req | start);
  end

  // Iteration step: acc upper half is the partial product / remainder,
  // lower half is the multiplier / dividend being shifted out.
  always_comb begin
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mc} : '0);
    mul_nxt = {add_sum, acc[XLEN-1:1]};
    shl_rem = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    sub_rem = shl_rem - {1'b0, mc};
    if (shl_rem >= {1'b0, mc}) div_nxt = {sub_rem[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else                       div_nxt = {shl_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  always_comb begin
    prod   = (is_signed && sign_q) ? -acc : acc;
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (is_div) begin
      if (divz) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_lo = neg_if(acc[XLEN-1:0], is_signed && sign_q);
        res_hi = neg_if(acc[2*XLEN-1:XLEN], is_signed && sign_r);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (wr_req) begin
            if (wr_sel) hi <= wr_data;
            else        lo <= wr_data;
          end
        end
        PREP: cnt <= '0;
        RUN:  if (!cancel) cnt <= cnt + 1'b1;
        FIX: begin
          if (!cancel) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Operand/accumulator datapath carries no reset; control gates every use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
        end
      end
      PREP: begin
        sign_q <= a_q[XLEN-1] ^ b_q[XLEN-1];
        sign_r <= a_q[XLEN-1];
        divz   <= (b_q == '0);
        if (is_div) begin
          acc <= {{XLEN{1'b0}}, mag(a_q, is_signed)};
          mc  <= mag(b_q, is_signed);
        end else begin
          acc <= {{XLEN{1'b0}}, mag(b_q, is_signed)};
          mc  <= mag(a_q, is_signed);
        end
      end
      RUN:     acc <= is_div ? div_nxt : mul_nxt;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl: arithmetic results, latency,
// stall behaviour, back-to-back issue, cancel and asynchronous reset.
module tb_muldiv_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            cancel = 1'b0;
  logic            rd_req = 1'b0;
  logic            wr_req = 1'b0;
  logic            wr_sel = 1'b0;
  logic [XLEN-1:0] wr_data = '0;
  logic            busy, done, stall;
  logic [XLEN-1:0] hi, lo;

  int total = 0;
  int bad = 0;

  muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .rd_req(rd_req), .wr_req(wr_req), .wr_sel(wr_sel),
    .wr_data(wr_data), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Drive start for exactly one posedge; returns at the negedge after it.
  task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done (bounded) and the busy cycles seen on the way.
  task automatic wait_done(output int lat, output int bcnt, output int overlap);
    lat = 0; bcnt = 0; overlap = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (done && busy) overlap = 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL reset_hilo hi=%h lo=%h want 0/0", hi, lo); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_ctrl busy=%b done=%b stall=%b want 000", busy, done, stall); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int lat, bc, ov;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc, ov);
    total++; if (lat !== 34) begin bad++; $display("FAIL multu_latency got=%0d want=34", lat); end
    total++; if (bc !== 34) begin bad++; $display("FAIL multu_busy_cycles got=%0d want=34", bc); end
    total++; if (ov !== 0) begin bad++; $display("FAIL multu_done_busy_overlap got=%0d want=0", ov); end
    total++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin bad++; $display("FAIL multu_result hi=%h lo=%h want fffffffe/00000001", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int lat, bc, ov;
    issue(2'b00, 32'hFFFFFFFD, 32'h7);
    wait_done(lat, bc, ov);
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_neg hi=%h lo=%h want ffffffff/ffffffeb", hi, lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_cycle_busy got=%b want=0", busy); end
    // issue DIVU in the done cycle itself
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b want=1", busy); end
    wait_done(lat, bc, ov);
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d want=34", lat); end
    total++; if (lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("FAIL divu_100_7 hi=%h lo=%h want 2/e", hi, lo); end
  endtask

  task automatic test_div;
    int lat, bc, ov;
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bc, ov);
    total++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_m7_2 hi=%h lo=%h want ffffffff/fffffffd", hi, lo); end
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bc, ov);
    total++; if (lo !== 32'h80000000 || hi !== 32'h0) begin bad++; $display("FAIL div_min_m1 hi=%h lo=%h want 0/80000000", hi, lo); end
    issue(2'b10, 32'd7, 32'hFFFFFFFE);
    wait_done(lat, bc, ov);
    total++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin bad++; $display("FAIL div_7_m2 hi=%h lo=%h want 1/fffffffd", hi, lo); end
  endtask

  task automatic test_div_zero;
    int lat, bc, ov;
    issue(2'b11, 32'd5, 32'd0);
    wait_done(lat, bc, ov);
    total++; if (lat !== 34) begin bad++; $display("FAIL divz_latency got=%0d want=34", lat); end
    total++; if (lo !== 32'hFFFFFFFF || hi !== 32'd5) begin bad++; $display("FAIL divu_by0 hi=%h lo=%h want 5/ffffffff", hi, lo); end
    issue(2'b10, 32'hFFFFFFF8, 32'd0);
    wait_done(lat, bc, ov);
    total++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF8) begin bad++; $display("FAIL div_by0 hi=%h lo=%h want fffffff8/ffffffff", hi, lo); end
  endtask

  task automatic test_hazards;
    int n, stall_err, busy_after;
    issue(2'b01, 32'd3, 32'd5);
    n = 0; stall_err = 0;
    while (!done && n < 100) begin
      rd_req = (n >= 3);
      wr_req = (n == 5); wr_sel = 1'b0; wr_data = 32'h1234;
      start  = (n == 7); op = 2'b00; a = 32'd2; b = 32'd2;
      #1;
      if (stall !== (n >= 3)) stall_err++;
      @(negedge clk);
      n++;
    end
    start = 1'b0; wr_req = 1'b0;
    #1;
    total++; if (stall_err !== 0) begin bad++; $display("FAIL stall_while_busy errors=%0d want=0", stall_err); end
    total++; if (n !== 34) begin bad++; $display("FAIL hazard_latency got=%0d want=34", n); end
    total++; if (stall !== 1'b0 || lo !== 32'd15 || hi !== 32'd0) begin bad++; $display("FAIL stall_release stall=%b hi=%h lo=%h want 0/0/f", stall, hi, lo); end
    @(negedge clk);
    rd_req = 1'b0;
    busy_after = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) busy_after++;
      @(negedge clk);
    end
    total++; if (busy_after !== 0) begin bad++; $display("FAIL start_while_busy_queued busy_cycles=%0d want=0", busy_after); end
  endtask

  task automatic test_idle_write;
    int lat, bc, ov;
    wr_req = 1'b1; wr_sel = 1'b1; wr_data = 32'h0000CAFE;
    @(negedge clk);
    wr_req = 1'b0;
    total++; if (hi !== 32'h0000CAFE || lo !== 32'd15) begin bad++; $display("FAIL idle_write_hi hi=%h lo=%h want cafe/f", hi, lo); end
    wr_req = 1'b1; wr_sel = 1'b0; wr_data = 32'h0000AAAA;
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    @(negedge clk);
    wr_req = 1'b0; start = 1'b0;
    total++; if (lo !== 32'h0000AAAA || busy !== 1'b1) begin bad++; $display("FAIL write_with_start lo=%h busy=%b want aaaa/1", lo, busy); end
    wait_done(lat, bc, ov);
    total++; if (lo !== 32'd6 || hi !== 32'd0) begin bad++; $display("FAIL write_then_fix hi=%h lo=%h want 0/6", hi, lo); end
  endtask

  task automatic test_cancel;
    int n, saw_done;
    @(negedge clk);
    wr_req = 1'b1; wr_sel = 1'b0; wr_data = 32'h1111;
    @(negedge clk);
    wr_sel = 1'b1; wr_data = 32'h2222;
    @(negedge clk);
    wr_req = 1'b0;
    issue(2'b00, 32'd6, 32'd7);
    for (n = 0; n < 10; n++) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b want=0", busy); end
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done++;
      @(negedge clk);
    end
    total++; if (saw_done !== 0) begin bad++; $display("FAIL cancel_done_pulses got=%0d want=0", saw_done); end
    total++; if (hi !== 32'h2222 || lo !== 32'h1111) begin bad++; $display("FAIL cancel_keep hi=%h lo=%h want 2222/1111", hi, lo); end
    cancel = 1'b1; start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_beats_start busy=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_run;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 15; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin bad++; $display("FAIL reset_mid_run hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_release busy=%b done=%b want 0/0", busy, done); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_back_to_back;
    test_div;
    test_div_zero;
    test_hazards;
    test_idle_write;
    test_cancel;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
